// File: rtl/program_loader.sv
// Byte-stream program loader: packs UART bytes big-endian into words for instruction memory.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module program_loader #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 32,
  parameter logic [DATA_BITS-1:0] HALT_WORD = {DATA_BITS{1'b1}}
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           i_rx_data,
  input  logic                 i_rx_valid,
  input  logic                 i_load_start,
  output logic                 o_write_inst_mem,
  output logic [ADDR_BITS-1:0] o_inst_mem_addr,
  output logic [DATA_BITS-1:0] o_inst_mem_data,
  output logic                 o_loading,
  output logic                 o_load_done,
  output logic                 o_overflow,
  output logic                 o_checksum_err
);

  localparam int BPW = DATA_BITS / 8;
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [CW-1:0] LAST = CW'(BPW - 1);
  localparam logic [ADDR_BITS-1:0] ADDR_MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
`ifdef LOADER_CHECKSUM_EN
    CHECK,
`endif
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_BITS-1:0] addr_q;
  logic [ADDR_BITS-1:0] mem_addr_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] mem_data_q;
  logic [CW-1:0]        cnt_q;
  logic                 ovf_q;
  logic [DATA_BITS-1:0] shift_nx;
  logic                 is_halt;
  logic                 last_byte;
  logic                 at_end;

  assign shift_nx  = {shift_q[DATA_BITS-9:0], i_rx_data};
  assign is_halt   = (mem_data_q == HALT_WORD);
  assign last_byte = (cnt_q == LAST);
  assign at_end    = (addr_q == ADDR_MAX);

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (i_load_start) state_d = RECV;
      RECV: if (i_rx_valid && last_byte) state_d = WRITE;
      WRITE: begin
        if (is_halt) begin
`ifdef LOADER_CHECKSUM_EN
          // a byte landing on the halt write is already the checksum
          state_d = i_rx_valid ? DONE : CHECK;
`else
          state_d = DONE;
`endif
        end else if (at_end) begin
          state_d = DONE;
        end else begin
          state_d = RECV;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: if (i_rx_valid) state_d = DONE;
`endif
      DONE: if (i_load_start) state_d = RECV;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_write_inst_mem = 1'b0;
    o_loading        = 1'b0;
    o_load_done      = 1'b0;
    unique case (state_q)
      IDLE: ;
      RECV: o_loading = 1'b1;
      WRITE: begin
        o_loading        = 1'b1;
        o_write_inst_mem = rst;
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: o_loading = 1'b1;
`endif
      DONE: o_load_done = 1'b1;
      default: ;
    endcase
  end

  assign o_inst_mem_addr = mem_addr_q;
  assign o_inst_mem_data = mem_data_q;
  assign o_overflow      = ovf_q;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] chk_q;
  logic       cerr_q;
  assign o_checksum_err = cerr_q;
`else
  assign o_checksum_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q     <= '0;
      mem_addr_q <= '0;
      shift_q    <= '0;
      mem_data_q <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      chk_q      <= '0;
      cerr_q     <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (i_load_start) begin
            addr_q  <= '0;
            cnt_q   <= '0;
            shift_q <= '0;
            ovf_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            chk_q   <= '0;
            cerr_q  <= 1'b0;
`endif
          end
        end
        RECV: begin
          if (i_rx_valid) begin
            shift_q <= shift_nx;
`ifdef LOADER_CHECKSUM_EN
            chk_q   <= chk_q ^ i_rx_data;
`endif
            if (last_byte) begin
              cnt_q      <= '0;
              mem_addr_q <= addr_q;
              mem_data_q <= shift_nx;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        WRITE: begin
          if (is_halt) begin
`ifdef LOADER_CHECKSUM_EN
            if (i_rx_valid) cerr_q <= (i_rx_data != chk_q);
`endif
          end else if (at_end) begin
            ovf_q <= 1'b1;
          end else begin
            addr_q <= addr_q + ADDR_BITS'(1);
            // the byte overlapping the write starts the next word
            if (i_rx_valid) begin
              shift_q <= shift_nx;
              cnt_q   <= cnt_q + CW'(1);
`ifdef LOADER_CHECKSUM_EN
              chk_q   <= chk_q ^ i_rx_data;
`endif
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CHECK: if (i_rx_valid) cerr_q <= (i_rx_data != chk_q);
`endif
        default: ;
      endcase
    end
  end

endmodule
